// File: rtl/weight_read_sequencer.sv
// Weight-memory read sequencer for one neuron: one read per accepted activation, addresses 0..N-1.
// Optional runtime weight loader on the memory write port, enabled with `define WEIGHT_LOADER_EN.
module weight_read_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_inputs,
    input  logic                  i_in_valid,
    output logic                  o_mem_ren,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_rvalid,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_weight_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_load_valid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_load_clear,
    output logic                  o_load_ready,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_N = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rcnt_q, rcnt_d;
    logic [ADDR_WIDTH:0]     n_q, n_d;
    logic                    last_q, last_d;

    logic [ADDR_WIDTH:0]     n_sat;
    logic [ADDR_WIDTH:0]     last_addr;
    logic                    is_last_addr;
    logic                    ren;

    // Requests beyond the memory depth are clamped so the pass still ends on the top address.
    assign n_sat        = (i_num_inputs > MAX_N) ? MAX_N : i_num_inputs;
    assign last_addr    = n_q - ONE_N;
    assign is_last_addr = ({1'b0, rcnt_q} == last_addr);
    assign ren          = (state_q == S_RUN) & i_in_valid;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        n_d     = n_q;
        last_d  = ren & is_last_addr;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d     = n_sat;
                    rcnt_d  = '0;
                    state_d = (n_sat == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (ren) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (is_last_addr) state_d = S_DRAIN;
                end
            end
            // Only the final read is outstanding here, so any returning data is the last weight.
            S_DRAIN: begin
                if (i_mem_rvalid) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            n_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            n_q     <= n_d;
            last_q  <= last_d;
        end
    end

    assign o_mem_ren      = ren;
    assign o_mem_raddr    = rcnt_q;
    assign o_weight       = i_mem_data;
    assign o_weight_valid = i_mem_rvalid & ((state_q == S_RUN) | (state_q == S_DRAIN));
    assign o_last         = last_q & o_weight_valid;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE);
    assign o_dbg_state    = state_q;

`ifdef WEIGHT_LOADER_EN
    logic [ADDR_WIDTH-1:0] lcnt_q, lcnt_d;
    logic                  load_acc;

    assign o_load_ready = (state_q == S_IDLE);
    assign load_acc     = i_load_valid & o_load_ready;

    // Clear wins over increment; a word accepted alongside a clear still uses the old address.
    always_comb begin
        lcnt_d = lcnt_q;
        if (i_load_clear)  lcnt_d = '0;
        else if (load_acc) lcnt_d = lcnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lcnt_q <= '0;
        else       lcnt_q <= lcnt_d;
    end

    assign o_mem_wen   = load_acc;
    assign o_mem_waddr = lcnt_q;
    assign o_mem_wdata = i_load_data;
`else
    logic unused_load;

    assign unused_load  = ^{i_load_valid, i_load_data, i_load_clear};
    assign o_load_ready = 1'b0;
    assign o_mem_wen    = 1'b0;
    assign o_mem_waddr  = '0;
    assign o_mem_wdata  = '0;
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Randomized bench for weight_read_sequencer with a transaction-level pass model and a memory model.
// Loader checks are compiled when WEIGHT_LOADER_EN is defined.
module tb_weight_read_sequencer;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_inputs = '0;
    logic          in_valid = 1'b0;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_data;
    logic          mem_rvalid;
    logic [DW-1:0] weight;
    logic          weight_valid;
    logic          last;
    logic          busy;
    logic          done;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_clear = 1'b0;
    logic          load_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    weight_read_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_inputs(num_inputs),
        .i_in_valid(in_valid), .o_mem_ren(mem_ren), .o_mem_raddr(mem_raddr),
        .i_mem_data(mem_data), .i_mem_rvalid(mem_rvalid), .o_weight(weight),
        .o_weight_valid(weight_valid), .o_last(last), .o_busy(busy), .o_done(done),
        .i_load_valid(load_valid), .i_load_data(load_data), .i_load_clear(load_clear),
        .o_load_ready(load_ready), .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr),
        .o_mem_wdata(mem_wdata), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model: 1-cycle registered read ----------------
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_data   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
        end else begin
            mem_rvalid <= mem_ren;
            if (mem_ren) mem_data <= mem[mem_raddr];
            if (mem_wen) mem[mem_waddr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // A pass of N (clamped to DEPTH) consumes the first N valid activations,
    // reading addresses 0..N-1 in order; each weight comes back one cycle later,
    // the N-th carries last, and done follows one cycle after it (or right after start when N=0).
    logic [DW-1:0] exp_q[$];
    bit            exp_last_q[$];
    bit            pass_active = 0;
    bit            arm = 0;
    bit            issued_prev = 0;
    bit            done_next = 0;
    int            reads_left = 0;
    int            next_addr = 0;
    int            pend_n = 0;
    bit            m_exp_done, m_idle, m_exp_ren, m_l;
    logic [DW-1:0] m_w;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_last_q.delete();
            pass_active = 0;
            arm         = 0;
            issued_prev = 0;
            done_next   = 0;
            reads_left  = 0;
            next_addr   = 0;
        end else begin
            m_exp_done = done_next;
            done_next  = 0;
            if (arm) begin
                arm         = 0;
                pass_active = 1;
                reads_left  = pend_n;
                next_addr   = 0;
                if (pend_n == 0) m_exp_done = 1;
            end
            m_idle = !pass_active;
            if (issued_prev) begin
                m_w = exp_q.pop_front();
                m_l = exp_last_q.pop_front();
                check("weight_valid", weight_valid, 1);
                check("weight", weight, m_w);
                check("last", last, m_l);
                if (m_l) done_next = 1;
            end else begin
                check("weight_valid_idle", weight_valid, 0);
                check("last_idle", last, 0);
            end
            check("busy", busy, pass_active);
            check("done", done, m_exp_done);
            if (m_exp_done) pass_active = 0;
            m_exp_ren = (reads_left > 0) && in_valid;
            check("mem_ren", mem_ren, m_exp_ren);
            if (m_exp_ren) begin
                check("raddr", 32'(mem_raddr), 32'(next_addr));
                exp_q.push_back(mem[next_addr]);
                exp_last_q.push_back(reads_left == 1);
                next_addr++;
                reads_left--;
            end
            issued_prev = m_exp_ren;
            if (start && m_idle) begin
                arm    = 1;
                pend_n = (int'(num_inputs) > DEPTH) ? DEPTH : int'(num_inputs);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_pass(input int prob);
        int cyc;
        cyc = 0;
        while ((pass_active || arm) && cyc < 3000) begin
            in_valid = ($urandom_range(0, 99) < prob);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("pass_ends", cyc < 3000, 1);
        tick();
    endtask

    task automatic run_pass(input int n, input int prob);
        start      = 1'b1;
        num_inputs = (AW+1)'(n);
        in_valid   = ($urandom_range(0, 99) < prob);
        tick();
        start = 1'b0;
        finish_pass(prob);
    endtask

`ifdef WEIGHT_LOADER_EN
    task automatic load_word(input logic [DW-1:0] d, input bit clr, input bit exp_acc, input int exp_addr);
        load_valid = 1'b1;
        load_data  = d;
        load_clear = clr;
        @(negedge clk);
        check("load_ready", load_ready, exp_acc);
        check("wen", mem_wen, exp_acc);
        if (exp_acc) begin
            check("waddr", 32'(mem_waddr), 32'(exp_addr));
            check("wdata", mem_wdata, d);
        end
        tick();
        load_valid = 1'b0;
        load_clear = 1'b0;
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        int pattern [5];
        pattern = '{1, 0, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_wvalid", weight_valid, 0);
        check("rst_wen", mem_wen, 0);
`ifdef WEIGHT_LOADER_EN
        check("rst_load_ready", load_ready, 1);
`else
        check("rst_load_ready", load_ready, 0);
`endif
        rst = 1'b0;
        tick();

        // N=4, activations every cycle
        run_pass(4, 100);

        // N=3 with valid pattern 1,0,0,1,1
        start = 1'b1;
        num_inputs = 11'd3;
        tick();
        start = 1'b0;
        foreach (pattern[i]) begin
            in_valid = pattern[i][0];
            tick();
        end
        finish_pass(0);

        // N=0: done right after start, no reads
        run_pass(0, 100);

        // start during RUN is ignored
        start = 1'b1;
        num_inputs = 11'd6;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        start = 1'b1;
        num_inputs = 11'd2;
        tick();
        start = 1'b0;
        finish_pass(70);

        // reset mid-RUN aborts the pass
        start = 1'b1;
        num_inputs = 11'd20;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ren", mem_ren, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        run_pass(5, 100);

        // randomized passes
        for (int p = 0; p < 20; p++) begin
            run_pass(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40), $urandom_range(30, 100));
        end

        // N above depth saturates
        run_pass(2047, 100);

`ifdef WEIGHT_LOADER_EN
        begin
            int laddr;
            logic [DW-1:0] d;
            laddr = 0;
            for (int i = 0; i < DEPTH + 1; i++) begin
                d = DW'($urandom);
                load_word(d, 1'b0, 1'b1, laddr);
                laddr = (laddr + 1) % DEPTH;
            end
            check("wrap_mem0", mem[0], d);
            run_pass(4, 100);

            // load attempts during RUN are refused
            start = 1'b1;
            num_inputs = 11'd8;
            tick();
            start = 1'b0;
            in_valid = 1'b1;
            repeat (3) begin
                load_valid = 1'b1;
                load_data = DW'($urandom);
                @(negedge clk);
                check("run_load_ready", load_ready, 0);
                check("run_wen", mem_wen, 0);
                tick();
            end
            load_valid = 1'b0;
            finish_pass(100);
            load_word(DW'($urandom), 1'b0, 1'b1, laddr);
            laddr = (laddr + 1) % DEPTH;

            // clear: word written at old address, next one at 0
            load_word(DW'($urandom), 1'b1, 1'b1, laddr);
            laddr = 0;
            load_word(DW'($urandom), 1'b0, 1'b1, laddr);
            laddr = 1;
            load_word(DW'($urandom), 1'b1, 1'b1, laddr);
            laddr = 0;

            // start and load in the same IDLE cycle: write lands before the first read
            d = DW'($urandom);
            start = 1'b1;
            num_inputs = 11'd2;
            load_valid = 1'b1;
            load_data = d;
            @(negedge clk);
            check("start_wen", mem_wen, 1);
            check("start_waddr", 32'(mem_waddr), 0);
            tick();
            start = 1'b0;
            load_valid = 1'b0;
            check("start_mem0", mem[0], d);
            finish_pass(100);
        end
`else
        load_valid = 1'b1;
        load_data = DW'($urandom);
        load_clear = 1'b1;
        @(negedge clk);
        check("noload_ready", load_ready, 0);
        check("noload_wen", mem_wen, 0);
        check("noload_waddr", 32'(mem_waddr), 0);
        check("noload_wdata", mem_wdata, 0);
        tick();
        load_valid = 1'b0;
        load_clear = 1'b0;
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
